// File: rtl/rv32_issue_scoreboard.sv
// rv32_issue_scoreboard: holds decoded instructions with pending source writes and issues them through a registered output stage
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      decoded instruction handshake
//   in_rd/in_rs1/in_rs2    register addresses, in_uses_rs1/in_uses_rs2/in_writes_rd usage flags
//   in_decode_error        illegal instruction; bypasses hazards, never marks rd
//   out_valid/out_ready    issued instruction handshake, out_* registered fields
//   wb_valid/wb_rd         per-port writeback completions (port i at wb_rd[5i+4:5i])
//   busy                   some register has an outstanding write
//   wb_underflow           sticky: a writeback arrived for a register with nothing outstanding
module rv32_issue_scoreboard #(
  parameter int PENDING_WIDTH = 2,
  parameter int WB_PORTS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic                  in_uses_rs1,
  input  logic                  in_uses_rs2,
  input  logic                  in_writes_rd,
  input  logic                  in_decode_error,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic                  out_writes_rd,
  output logic                  out_decode_error,
  input  logic [WB_PORTS-1:0]   wb_valid,
  input  logic [5*WB_PORTS-1:0] wb_rd,
  output logic                  busy,
  output logic                  wb_underflow
);
  localparam int SW = PENDING_WIDTH + $clog2(WB_PORTS + 1) + 1;
  localparam logic [PENDING_WIDTH-1:0] MAX = '1;
  logic [31:0][PENDING_WIDTH-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d, out_writes_rd_q, out_writes_rd_d, out_decode_error_q, out_decode_error_d;
  logic [4:0] out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic busy_q, busy_d, wb_underflow_q, wb_underflow_d;
  logic eff_writes, hazard, transfer;
  logic [SW-1:0] up, dn;
  always_comb begin
    eff_writes = in_writes_rd && in_rd != 5'd0 && !in_decode_error;
    hazard = !in_decode_error && ((in_uses_rs1 && cnt_q[in_rs1] != '0) ||
                                  (in_uses_rs2 && cnt_q[in_rs2] != '0) ||
                                  (eff_writes && cnt_q[in_rd] == MAX));
    in_ready = !rst && !hazard && (!out_valid_q || out_ready);
    transfer = in_valid && in_ready;
    out_valid_d = transfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_rd_d = transfer ? in_rd : out_rd_q;
    out_rs1_d = transfer ? in_rs1 : out_rs1_q;
    out_rs2_d = transfer ? in_rs2 : out_rs2_q;
    out_writes_rd_d = transfer ? eff_writes : out_writes_rd_q;
    out_decode_error_d = transfer ? in_decode_error : out_decode_error_q;
    cnt_d = '0;
    wb_underflow_d = wb_underflow_q;
    up = '0;
    dn = '0;
    // x0 is skipped so its counter stays 0 and writebacks to it are dropped
    for (int r = 1; r < 32; r++) begin
      up = SW'(cnt_q[r]) + SW'(transfer && eff_writes && in_rd == 5'(r));
      dn = '0;
      for (int p = 0; p < WB_PORTS; p++) dn = dn + SW'(wb_valid[p] && wb_rd[5*p +: 5] == 5'(r));
      // more completions than outstanding writes: clamp and remember the error
      wb_underflow_d = wb_underflow_d || (dn > up);
      cnt_d[r] = (dn > up) ? '0 : PENDING_WIDTH'(up - dn);
    end
    busy_d = |cnt_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_rd_q <= '0;
      out_rs1_q <= '0;
      out_rs2_q <= '0;
      out_writes_rd_q <= 1'b0;
      out_decode_error_q <= 1'b0;
      busy_q <= 1'b0;
      wb_underflow_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_valid_q <= out_valid_d;
      out_rd_q <= out_rd_d;
      out_rs1_q <= out_rs1_d;
      out_rs2_q <= out_rs2_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_decode_error_q <= out_decode_error_d;
      busy_q <= busy_d;
      wb_underflow_q <= wb_underflow_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_rd = out_rd_q;
  assign out_rs1 = out_rs1_q;
  assign out_rs2 = out_rs2_q;
  assign out_writes_rd = out_writes_rd_q;
  assign out_decode_error = out_decode_error_q;
  assign busy = busy_q;
  assign wb_underflow = wb_underflow_q;
endmodule

// File: doc/rv32_issue_scoreboard.md
Name: rv32_issue_scoreboard

Overview:
Issue-control stage between the rv32 decoder and the execute units. It takes decoded instruction fields (rd/rs1/rs2 plus usage flags) and holds any instruction whose source registers have outstanding writes. It tracks in-flight destination writes per architectural register with small counters, which are released by writeback ports. It presents issued fields through a registered valid/ready output stage.

Parameters:
PENDING_WIDTH, 2, width of each per-register outstanding-write counter; maximum outstanding writes per register = 2^PENDING_WIDTH-1.
WB_PORTS, 2, number of independent writeback-completion ports.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  decoded instruction valid
in_ready  output  1  stage accepts the instruction this cycle
in_rd / in_rs1 / in_rs2  input  5 each  register addresses (rv32_reg_addr_t)
in_uses_rs1 / in_uses_rs2  input  1 each  instruction reads rs1/rs2
in_writes_rd  input  1  instruction writes rd
in_decode_error  input  1  decoder flagged the instruction as illegal
out_valid  output  1  issued instruction valid
out_ready  input  1  downstream accepts
out_rd / out_rs1 / out_rs2  output  5 each  registered copies of the issued fields
out_writes_rd  output  1  registered; forced 0 when rd==0 or decode_error
out_decode_error  output  1  registered copy
wb_valid  input  WB_PORTS  per-port writeback completion
wb_rd  input  5*WB_PORTS  per-port completed destination (port i at bits [5i+4:5i])
busy  output  1  any counter nonzero
wb_underflow  output  1  sticky error flag

Behaviour:
- Reset (async, rst=1): all counters=0; out_valid=0; out_rd/out_rs1/out_rs2=0; out_writes_rd=0; out_decode_error=0; busy=0; wb_underflow=0; in_ready=0 while rst is high.
- Register x0 is never tracked: its counter is constant 0, and wb to rd=0 is ignored.
- Hazard (combinational, from registered counter state only; same-cycle writebacks are not bypassed):
  - (in_uses_rs1 && cnt[rs1]!=0), or
  - (in_uses_rs2 && cnt[rs2]!=0), or
  - (eff_writes && cnt[rd]==MAX).
  - eff_writes = in_writes_rd && rd!=0 && !in_decode_error.
- When in_decode_error=1, hazard is forced 0 and no counter is marked. The instruction flows to execute, which raises the trap.
- in_ready = !rst && !hazard && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
- Output stage is a single register. Latency from in-transfer to out_valid is 1 cycle.
  - On transfer: load fields, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - Outputs are held stable while out_valid && !out_ready.
- Counter update per register r each cycle: cnt[r] <= cnt[r] + inc[r] - dec[r].
  - inc[r] = transfer && eff_writes && rd==r.
  - dec[r] = number of wb ports with wb_valid && wb_rd==r.
  - A simultaneous issue-mark and writeback on the same register nets correctly; for example, inc 1 and dec 1 leaves the counter unchanged.
  - If dec exceeds cnt+inc, the counter clamps to 0 and wb_underflow<=1. The flag stays set until reset.
- WAW is permitted: multiple outstanding writes to one rd are allowed up to MAX. Reads of that register stall until the counter returns to 0.
- busy is registered and equals OR of all counters after the update.
- Reset mid-operation clears all counters and drops out_valid immediately. Writebacks arriving after reset for pre-reset instructions are counted as underflow.

Test Plan:
- Back-to-back independent ops (rd=1,rs=2/3 then rd=4,rs=5/6), out_ready=1 -> both issue on consecutive cycles, out_valid 1 cycle after each transfer, cnt[1]=1, cnt[4]=1, busy=1.
- RAW: issue rd=5, then rs1=5 held -> in_ready=0; wb_valid[0]=1, wb_rd=5 at cycle T -> in_ready=1 at T+1, consumer issues.
- Same-cycle issue rd=7 plus wb rd=7 with cnt[7]=1 -> cnt[7] stays 1. Two wb ports both rd=7 with cnt[7]=2 -> cnt[7]=0.
- WAW saturation (PENDING_WIDTH=2): three issues writing rd=9 -> fourth write to rd=9 stalls until one wb; rd=0 writes never stall or mark; decode_error with busy sources issues immediately with out_writes_rd=0.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, outputs stable for 5 cycles; release -> next instruction loads same cycle.
- wb rd=3 with cnt[3]=0 -> wb_underflow=1, cnt[3]=0; assert rst mid-stream -> out_valid=0, busy=0, wb_underflow=0 asynchronously.
